// File: rtl/tt_um_cla_word_sequencer_pkg.sv
// Shared definitions for the byte-serial CLA word sequencer: state encoding,
// control/status bit positions on the uio bus and the fixed output-enable mask.
package tt_um_cla_word_sequencer_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COMPUTE = 2'd1,
    DONE    = 2'd2
  } state_e;

  // uio_in control bit positions
  localparam int UIO_WR    = 0;
  localparam int UIO_SEL   = 1;
  localparam int UIO_START = 2;
  localparam int UIO_SUB   = 3;
  localparam int UIO_CLR   = 4;

  // uio_out status bit positions
  localparam int UIO_BUSY  = 5;
  localparam int UIO_DONE  = 6;
  localparam int UIO_CFLAG = 7;

  // Only the three status bits are driven outward
  localparam logic [7:0] UIO_OE_VAL = 8'b1110_0000;

endpackage

// File: rtl/tt_um_cla_word_sequencer_cla8.sv
// 8-bit carry-lookahead adder slice with carry-in. Every carry is formed
// directly from the generate/propagate terms and cin (no rippling chain),
// so the slice depth stays flat regardless of bit position.
module cla8_cin (
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       cin,
  output logic [7:0] sum,
  output logic       cout
);

  logic [7:0] g;
  logic [7:0] p;
  logic [8:0] c;

  // Lookahead carries: c[k] = OR_j (g[j] & p[j+1..k-1]) | (cin & p[0..k-1])
  always_comb begin : lookahead
    logic acc;
    logic term;
    g = a & b;
    p = a ^ b;
    c = '0;
    for (int k = 0; k <= 8; k++) begin
      term = cin;
      for (int j = 0; j < k; j++) begin
        term = term & p[j];
      end
      acc = term;
      for (int j = 0; j < k; j++) begin
        term = g[j];
        for (int m = j + 1; m < k; m++) begin
          term = term & p[m];
        end
        acc = acc | term;
      end
      c[k] = acc;
    end
  end

  assign sum  = p ^ c[7:0];
  assign cout = c[8];

endmodule

// File: rtl/tt_um_cla_word_sequencer.sv
// Byte-serial word adder/subtractor. Operands A and B are loaded one byte at
// a time, then one shared 8-bit CLA slice walks the bytes LSB first, one per
// clock. Results are read back a byte at a time through uo_out.
module tt_um_cla_word_sequencer
  import tt_um_cla_word_sequencer_pkg::*;
#(
  parameter int OPW = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  localparam int             IW   = (OPW > 1) ? $clog2(OPW) : 1;
  localparam logic [IW-1:0]  LAST = IW'(OPW - 1);

  state_e                state_q, state_d;
  logic [OPW-1:0][7:0]   a_q, a_d;
  logic [OPW-1:0][7:0]   b_q, b_d;
  logic [OPW-1:0][7:0]   r_q, r_d;
  logic [IW-1:0]         wp_a_q, wp_a_d;
  logic [IW-1:0]         wp_b_q, wp_b_d;
  logic [IW-1:0]         rp_q, rp_d;
  logic [IW-1:0]         i_q, i_d;
  logic                  carry_q, carry_d;
  logic                  cflag_q, cflag_d;
  logic                  op_sub_q, op_sub_d;

  logic                  wr, sel, start, sub, clr;
  logic [7:0]            slice_a, slice_b, slice_sum;
  logic                  slice_cout;
  logic                  unused_inputs;

  assign wr    = uio_in[UIO_WR];
  assign sel   = uio_in[UIO_SEL];
  assign start = uio_in[UIO_START];
  assign sub   = uio_in[UIO_SUB];
  assign clr   = uio_in[UIO_CLR];

  assign unused_inputs = &{1'b0, ena, uio_in[7:5]};

  // Circular pointer advance over the OPW byte positions
  function automatic logic [IW-1:0] ptr_inc(input logic [IW-1:0] ptr);
    return (ptr == LAST) ? '0 : ptr + 1'b1;
  endfunction

  // Subtraction is A + ~B + 1: invert B here, the +1 enters as the initial carry
  assign slice_a = a_q[i_q];
  assign slice_b = op_sub_q ? ~b_q[i_q] : b_q[i_q];

  cla8_cin u_cla (
    .a    (slice_a),
    .b    (slice_b),
    .cin  (carry_q),
    .sum  (slice_sum),
    .cout (slice_cout)
  );

  // Next-state, operand loading, byte stepping and readback pointer
  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    r_d      = r_q;
    wp_a_d   = wp_a_q;
    wp_b_d   = wp_b_q;
    rp_d     = rp_q;
    i_d      = i_q;
    carry_d  = carry_q;
    cflag_d  = cflag_q;
    op_sub_d = op_sub_q;

    case (state_q)
      IDLE: begin
        // A write on the start edge lands before the first byte step reads it
        if (wr) begin
          if (sel) begin
            b_d[wp_b_q] = ui_in;
            wp_b_d      = ptr_inc(wp_b_q);
          end else begin
            a_d[wp_a_q] = ui_in;
            wp_a_d      = ptr_inc(wp_a_q);
          end
        end
        if (start) begin
          op_sub_d = sub;
          carry_d  = sub;
          i_d      = '0;
          state_d  = COMPUTE;
        end
      end
      COMPUTE: begin
        r_d[i_q] = slice_sum;
        carry_d  = slice_cout;
        if (i_q == LAST) begin
          cflag_d = slice_cout;
          i_d     = '0;
          state_d = DONE;
        end else begin
          i_d = i_q + 1'b1;
        end
      end
      DONE: begin
        if (start) begin
          op_sub_d = sub;
          carry_d  = sub;
          i_d      = '0;
          rp_d     = '0;
          state_d  = COMPUTE;
        end else if (wr) begin
          rp_d = ptr_inc(rp_q);
        end
      end
      default: state_d = IDLE;
    endcase

    if (clr) begin
      state_d  = IDLE;
      a_d      = '0;
      b_d      = '0;
      r_d      = '0;
      wp_a_d   = '0;
      wp_b_d   = '0;
      rp_d     = '0;
      i_d      = '0;
      carry_d  = 1'b0;
      cflag_d  = 1'b0;
      op_sub_d = 1'b0;
    end
  end

  // State and datapath registers; reset clears everything just like clr
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      r_q      <= '0;
      wp_a_q   <= '0;
      wp_b_q   <= '0;
      rp_q     <= '0;
      i_q      <= '0;
      carry_q  <= 1'b0;
      cflag_q  <= 1'b0;
      op_sub_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      r_q      <= r_d;
      wp_a_q   <= wp_a_d;
      wp_b_q   <= wp_b_d;
      rp_q     <= rp_d;
      i_q      <= i_d;
      carry_q  <= carry_d;
      cflag_q  <= cflag_d;
      op_sub_q <= op_sub_d;
    end
  end

  // Result byte is only exposed once the whole word is complete
  always_comb begin
    uo_out             = 8'h00;
    uio_out            = 8'h00;
    if (state_q == DONE) begin
      uo_out = r_q[rp_q];
    end
    uio_out[UIO_BUSY]  = (state_q == COMPUTE);
    uio_out[UIO_DONE]  = (state_q == DONE);
    uio_out[UIO_CFLAG] = cflag_q;
  end

  assign uio_oe = UIO_OE_VAL;

endmodule

// File: tb/tb_tt_um_cla_word_sequencer.sv
// Bench for the byte-serial CLA word sequencer. Stimulus pushes the expected
// result bytes into a scoreboard; a monitor pops one entry each time the DUT
// presents a new result byte (entry into DONE or a readback step).
module tb_tt_um_cla_word_sequencer;
  import tt_um_cla_word_sequencer_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ena = 1'b1;
  logic [7:0] ui_in = 8'h00;
  logic [7:0] uio_in = 8'h00;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  int n_vec = 0;
  int n_bad = 0;

  logic [7:0] exp_byte[$];
  logic       exp_cf[$];
  string      exp_tag[$];

  always #5 clk = ~clk;

  tt_um_cla_word_sequencer #(.OPW(4)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ena     (ena),
    .ui_in   (ui_in),
    .uio_in  (uio_in),
    .uo_out  (uo_out),
    .uio_out (uio_out),
    .uio_oe  (uio_oe)
  );

  task automatic check8(input string name, input logic [7:0] act, input logic [7:0] req);
    n_vec++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %02h required %02h", name, act, req);
    end
  endtask

  function automatic logic [7:0] ctl(input bit wr, input bit sel, input bit start,
                                     input bit sub, input bit clr);
    return {3'b000, clr, sub, start, sel, wr};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_clr();
    uio_in = ctl(0, 0, 0, 0, 1);
    tick();
    uio_in = 8'h00;
  endtask

  task automatic write_word(input bit sel, input logic [31:0] w);
    for (int k = 0; k < 4; k++) begin
      ui_in  = w[8*k +: 8];
      uio_in = ctl(1, sel, 0, 0, 0);
      tick();
    end
    uio_in = 8'h00;
  endtask

  // Issue start, check the 4 busy cycles and exact latency, then step readback.
  task automatic run(input string tag, input bit sub, input logic [31:0] res,
                     input bit cf, input bit noise, input bit with_wr);
    for (int k = 0; k < 4; k++) begin
      exp_byte.push_back(res[8*k +: 8]);
      exp_cf.push_back(cf);
      exp_tag.push_back($sformatf("%s_byte%0d", tag, k));
    end
    uio_in = ctl(with_wr, 0, 1, sub, 0);
    tick();
    uio_in = 8'h00;
    for (int c = 1; c <= 4; c++) begin
      check8({tag, "_busy"}, {7'b0, uio_out[UIO_BUSY]}, 8'h01);
      check8({tag, "_uo_in_compute"}, uo_out, 8'h00);
      if (noise && c == 2) begin
        ui_in  = 8'hAA;
        uio_in = ctl(1, 0, 1, ~sub, 0);
      end else if (noise && c == 3) begin
        uio_in = ctl(1, 1, 1, sub, 0);
      end else begin
        uio_in = 8'h00;
      end
      tick();
    end
    uio_in = 8'h00;
    check8({tag, "_done_latency"}, {7'b0, uio_out[UIO_DONE]}, 8'h01);
    for (int w = 0; w < 8 && !uio_out[UIO_DONE]; w++) tick();
    if (!uio_out[UIO_DONE]) begin
      n_vec++;
      n_bad++;
      $display("FAIL %s_timeout: done=0 required 1", tag);
      return;
    end
    for (int k = 1; k < 4; k++) begin
      ui_in  = 8'hEE;
      uio_in = ctl(1, 0, 0, 0, 0);
      tick();
    end
    uio_in = 8'h00;
  endtask

  // Monitor: a new result byte is presented on entry to DONE or after a readback step
  initial begin : monitor
    logic prev_done;
    logic prev_adv;
    logic present;
    logic [7:0] eb;
    logic       ec;
    string      et;
    prev_done = 1'b0;
    prev_adv  = 1'b0;
    forever begin
      @(negedge clk);
      present = (uio_out[UIO_DONE] === 1'b1) && (!prev_done || prev_adv);
      if (present) begin
        if (exp_byte.size() == 0) begin
          n_vec++;
          n_bad++;
          $display("FAIL unexpected_byte: got %02h required none", uo_out);
        end else begin
          eb = exp_byte.pop_front();
          ec = exp_cf.pop_front();
          et = exp_tag.pop_front();
          check8(et, uo_out, eb);
          check8({et, "_cflag"}, {7'b0, uio_out[UIO_CFLAG]}, {7'b0, ec});
        end
      end
      prev_adv  = (uio_out[UIO_DONE] === 1'b1) && uio_in[UIO_WR] && !uio_in[UIO_START]
                  && !uio_in[UIO_CLR] && rst_n;
      prev_done = (uio_out[UIO_DONE] === 1'b1);
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    // Reset held two cycles
    rst_n = 1'b0;
    tick();
    tick();
    check8("rst_uo_out", uo_out, 8'h00);
    check8("rst_uio_out", uio_out, 8'h00);
    check8("rst_uio_oe", uio_oe, 8'hE0);
    check8("rst_busy", {7'b0, uio_out[UIO_BUSY]}, 8'h00);
    check8("rst_done", {7'b0, uio_out[UIO_DONE]}, 8'h00);
    rst_n = 1'b1;
    tick();
    check8("idle_uo_out", uo_out, 8'h00);

    // Carry across byte 0 into byte 1
    write_word(0, 32'h0000_00FF);
    write_word(1, 32'h0000_0001);
    run("carry", 0, 32'h0000_0100, 0, 0, 0);
    // Recompute from DONE with held operands as a subtraction
    run("rerun_sub", 1, 32'h0000_00FE, 1, 0, 0);

    // Full-width carry out
    do_clr();
    write_word(0, 32'hFFFF_FFFF);
    write_word(1, 32'h0000_0001);
    run("fullcarry", 0, 32'h0000_0000, 1, 0, 0);

    // Borrow and no-borrow subtraction
    do_clr();
    write_word(0, 32'h0000_0005);
    write_word(1, 32'h0000_0007);
    run("sub_borrow", 1, 32'hFFFF_FFFE, 0, 0, 0);
    do_clr();
    write_word(0, 32'h0000_0007);
    write_word(1, 32'h0000_0005);
    run("sub_noborrow", 1, 32'h0000_0002, 1, 0, 0);

    // Write pointer wrap: fifth byte overwrites byte 0
    do_clr();
    for (int k = 1; k <= 5; k++) begin
      ui_in  = 8'(k * 8'h11);
      uio_in = ctl(1, 0, 0, 0, 0);
      tick();
    end
    uio_in = 8'h00;
    run("ptr_wrap", 0, 32'h4433_2255, 0, 0, 0);

    // Writes/start during COMPUTE and writes during DONE are ignored
    do_clr();
    write_word(0, 32'h0102_0304);
    write_word(1, 32'h1020_3040);
    run("ignore_compute", 0, 32'h1122_3344, 0, 1, 0);
    run("ignore_rerun", 0, 32'h1122_3344, 0, 0, 0);

    // Write and start on the same edge: the written byte is used
    do_clr();
    write_word(1, 32'h8000_0000);
    for (int k = 0; k < 3; k++) begin
      ui_in  = 8'h00;
      uio_in = ctl(1, 0, 0, 0, 0);
      tick();
    end
    ui_in = 8'h80;
    run("wr_with_start", 0, 32'h0000_0000, 1, 0, 1);

    // clr on the second COMPUTE cycle
    do_clr();
    write_word(0, 32'hFFFF_FFFF);
    write_word(1, 32'hFFFF_FFFF);
    uio_in = ctl(0, 0, 1, 0, 0);
    tick();
    uio_in = 8'h00;
    tick();
    uio_in = ctl(0, 0, 0, 0, 1);
    tick();
    uio_in = 8'h00;
    check8("clr_mid_busy", {7'b0, uio_out[UIO_BUSY]}, 8'h00);
    check8("clr_mid_done", {7'b0, uio_out[UIO_DONE]}, 8'h00);
    check8("clr_mid_uo_out", uo_out, 8'h00);
    check8("clr_mid_uio_out", uio_out, 8'h00);
    ui_in  = 8'h12;
    uio_in = ctl(1, 0, 0, 0, 0);
    tick();
    uio_in = 8'h00;
    run("after_clr", 0, 32'h0000_0012, 0, 0, 0);

    // Reset during COMPUTE behaves like clr
    uio_in = ctl(0, 0, 1, 0, 0);
    tick();
    uio_in = 8'h00;
    tick();
    rst_n = 1'b0;
    tick();
    check8("rst_mid_uio_oe", uio_oe, 8'hE0);
    rst_n = 1'b1;
    check8("rst_mid_uo_out", uo_out, 8'h00);
    check8("rst_mid_uio_out", uio_out, 8'h00);
    ui_in  = 8'h34;
    uio_in = ctl(1, 0, 0, 0, 0);
    tick();
    uio_in = 8'h00;
    run("after_rst", 0, 32'h0000_0034, 0, 0, 0);

    tick();
    tick();
    check8("scoreboard_drain", 8'(exp_byte.size()), 8'h00);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/tt_um_cla_word_sequencer.md
TT_UM_CLA_WORD_SEQUENCER -- requirements
Module: tt_um_cla_word_sequencer

Interface
REQ-001 The module SHALL have a parameter OPW, default 4, giving the number of 8-bit bytes per operand (32-bit word).
REQ-002 The module SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-003 The module SHALL have port rst_n  input  1  reset, synchronous and active-low.
REQ-004 The module SHALL have port ena  input  1  always 1 when powered; unused.
REQ-005 The module SHALL have port ui_in  input  8  operand byte data.
REQ-006 The module SHALL have port uio_in  input  8  control inputs: [0] wr/next, [1] sel (0=A, 1=B), [2] start, [3] sub, [4] clr; [7:5] unused.
REQ-007 The module SHALL have port uo_out  output  8  result byte.
REQ-008 The module SHALL have port uio_out  output  8  status outputs: [5] busy, [6] done, [7] cflag; [4:0] driven 0.
REQ-009 The module SHALL have port uio_oe  output  8  constant 8'b1110_0000.

Function
REQ-010 The module SHALL use states IDLE, COMPUTE and DONE.
REQ-011 In IDLE, when wr=1, the module SHALL write ui_in into byte wp_A of operand A (sel=0) or byte wp_B of operand B (sel=1), then increment that pointer; the pointer wraps OPW-1 to 0.
REQ-012 In IDLE, when start=1, the module SHALL latch sub into op_sub, set carry=sub and byte index i=0, and enter COMPUTE.
REQ-013 When wr and start are both 1 in IDLE, the module SHALL commit the write on the same edge, and the computation SHALL use the written byte.
REQ-014 In COMPUTE, on each cycle the module SHALL pass A[i] and (op_sub ? ~B[i] : B[i]) with carry into one shared 8-bit CLA slice, store the sum in R[i], load the slice carry-out into carry, and increment i.
REQ-015 After the cycle with i=OPW-1, the module SHALL set cflag=carry and enter DONE; latency is exactly OPW edges after the start edge.
REQ-016 cflag SHALL mean carry-out for add and no-borrow for sub (1 = A>=B unsigned).
REQ-017 busy SHALL be 1 exactly in COMPUTE; done SHALL be 1 exactly in DONE.
REQ-018 In DONE, uo_out SHALL equal R[rp]; in IDLE and COMPUTE, uo_out SHALL be 0x00.
REQ-019 In DONE, wr=1 SHALL increment rp, wrapping OPW-1 to 0; writes and sel SHALL be ignored in DONE.
REQ-020 In DONE, start=1 SHALL recompute with the held operands and the current sub, reset rp to 0 and enter COMPUTE; if wr is also 1, start wins.
REQ-021 In COMPUTE, wr, start and sub SHALL be ignored.
REQ-022 In any state, clr=1 SHALL take priority over all other controls: next state IDLE; A, B, R, pointers, carry and cflag cleared to 0.
REQ-023 All arithmetic SHALL be modulo 2^(8*OPW); the final carry SHALL be reported only through cflag.

Reset
REQ-024 With rst_n=0 at a clock edge, the module SHALL enter IDLE and set A, B and R to 0, wp_A, wp_B, rp and i to 0, carry and cflag to 0, uo_out=0x00 and uio_out=0x00.
REQ-025 Reset SHALL behave identically to clr, including mid-COMPUTE, with no partial result retained.
REQ-026 uio_oe SHALL stay 8'b1110_0000 during reset.

Structure
REQ-027 A shared package SHALL hold the state encoding (IDLE/COMPUTE/DONE), the uio_in/uio_out bit-index constants and the UIO_OE_VAL constant.
REQ-028 The 8-bit carry-lookahead adder with carry-in (g/p generation, lookahead carries, sum, cout) SHALL be one sub-module, cla8_cin, instantiated once and shared across all byte steps.
REQ-029 The sequencer FSM, operand/result registers and pointers SHALL live in the top module.

Verification
REQ-030 Reset test: hold rst_n low 2 cycles -> uo_out=0x00, uio_out=0x00, uio_oe=0xE0, busy=0, done=0.
REQ-031 Carry test: A=0x000000FF, B=0x00000001, add -> busy for 4 cycles, then done; rp reads 0x00,0x01,0x00,0x00; cflag=0.
REQ-032 Full-width carry test: A=0xFFFFFFFF, B=0x00000001, add -> result 0x00000000, cflag=1.
REQ-033 Subtract test: A=0x00000005, B=0x00000007, sub=1 -> result 0xFFFFFFFE, cflag=0; then swap operands -> result 0x00000002, cflag=1.
REQ-034 Pointer-wrap test: write 0x11,0x22,0x33,0x44,0x55 to A -> A=0x44332255 (byte0=0x55).
REQ-035 Clear/ignore test: clr asserted on the 2nd COMPUTE cycle -> IDLE on the next cycle, busy=0, uo_out=0x00, all registers 0; separately, start/wr pulses during COMPUTE produce no change.
